// File: rtl/free_list.sv
// Physical-register free list: circular FIFO of free tags feeding rename allocation
// and absorbing tags released at retirement or reclaimed on a branch flush.
module free_list #(
    parameter int N_WAY    = 2,
    parameter int N_ROB    = 8,
    parameter int N_AREG   = 32,
    parameter int N_PREG   = 64,
    parameter int TAG_BITS = $clog2(N_PREG)
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [N_WAY-1:0]                   retire_valid,
    input  logic [N_WAY-1:0][TAG_BITS-1:0]     retire_told,
    input  logic                               branch_haz,
    input  logic [N_ROB-1:0][TAG_BITS-1:0]     free_list_haz,
    input  logic [N_WAY-1:0]                   alloc_req,
    output logic [N_WAY-1:0][TAG_BITS-1:0]     alloc_tag,
    output logic [N_WAY-1:0]                   alloc_valid,
    output logic [TAG_BITS:0]                  free_count,
    output logic [$clog2(N_WAY):0]             avail,
    output logic                               overflow_err
);

    localparam int N_PUSH = N_WAY + N_ROB;
    localparam int CNT_W  = TAG_BITS + 2;
    localparam int AV_W   = $clog2(N_WAY) + 1;
    localparam logic [CNT_W-1:0]    ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0]    DEPTH     = CNT_W'(N_PREG);
    localparam logic [TAG_BITS:0]   WAY_CNT   = (TAG_BITS+1)'(N_WAY);
    localparam logic [TAG_BITS:0]   INIT_FREE = (TAG_BITS+1)'(N_PREG - N_AREG);

    logic [TAG_BITS-1:0] mem [N_PREG];
    logic [TAG_BITS-1:0] head;
    logic [TAG_BITS-1:0] tail;

    logic [CNT_W-1:0]    rank;
    logic [CNT_W-1:0]    n_pop;
    logic [CNT_W-1:0]    n_push;
    logic [CNT_W-1:0]    proj;
    logic                drop;

    logic [N_PUSH-1:0]   cand_v;
    logic [TAG_BITS-1:0] cand_tag  [N_PUSH];
    logic [N_PUSH-1:0]   push_en;
    logic [TAG_BITS-1:0] push_addr [N_PUSH];

    // Grants go to requesting ways in order; a way's rank counts every earlier
    // request, so a request beyond the free count is refused even if gaps exist.
    // NOTE: combinational blocks use blocking '=' with every output defaulted first,
    // so the running counters behave like software and no latch is inferred.
    always_comb begin
        rank        = '0;
        n_pop       = '0;
        alloc_valid = '0;
        alloc_tag   = '0;
        for (int i = 0; i < N_WAY; i++) begin
            if (alloc_req[i]) begin
                if (!branch_haz && rank < CNT_W'(free_count)) begin
                    alloc_valid[i] = 1'b1;
                    alloc_tag[i]   = mem[head + rank[TAG_BITS-1:0]];
                    n_pop          = n_pop + ONE;
                end
                rank = rank + ONE;
            end
        end
    end

    always_comb begin
        avail = (free_count < WAY_CNT) ? free_count[AV_W-1:0] : AV_W'(N_WAY);
    end

    // Push candidates: retire ways first, then flushed in-flight tags; tag 0 is "none".
    always_comb begin
        for (int i = 0; i < N_WAY; i++) begin
            cand_v[i]   = retire_valid[i] && (retire_told[i] != '0);
            cand_tag[i] = retire_told[i];
        end
        for (int j = 0; j < N_ROB; j++) begin
            cand_v[N_WAY+j]   = branch_haz && (free_list_haz[j] != '0);
            cand_tag[N_WAY+j] = free_list_haz[j];
        end
    end

    // Accepted pushes are compacted at tail; the capacity test uses the count
    // after this cycle's pops so a full list can still recycle a granted tag.
    always_comb begin
        proj   = CNT_W'(free_count) - n_pop;
        n_push = '0;
        drop   = 1'b0;
        for (int k = 0; k < N_PUSH; k++) begin
            push_en[k]   = 1'b0;
            push_addr[k] = tail + n_push[TAG_BITS-1:0];
            if (cand_v[k]) begin
                if (proj < DEPTH) begin
                    push_en[k] = 1'b1;
                    proj       = proj + ONE;
                    n_push     = n_push + ONE;
                end else begin
                    drop = 1'b1;
                end
            end
        end
    end

    // NOTE: the tag storage is reset on purpose: the initial free tags live in it,
    // so unlike a plain data buffer its contents are architectural state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_PREG; i++) begin
                mem[i] <= (i < N_PREG - N_AREG) ? TAG_BITS'(N_AREG + i) : '0;
            end
            head         <= '0;
            tail         <= TAG_BITS'(N_PREG - N_AREG);
            free_count   <= INIT_FREE;
            overflow_err <= 1'b0;
        end else begin
            for (int k = 0; k < N_PUSH; k++) begin
                if (push_en[k]) begin
                    mem[push_addr[k]] <= cand_tag[k];
                end
            end
            head       <= head + n_pop[TAG_BITS-1:0];
            tail       <= tail + n_push[TAG_BITS-1:0];
            free_count <= proj[TAG_BITS:0];
            if (drop) begin
                overflow_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_free_list.sv
// Scoreboard bench for free_list: a queue-of-tags reference model predicts each
// cycle's outputs, which are queued at drive time and compared at the falling edge.
module tb_free_list;

    localparam int N_WAY = 2;
    localparam int N_ROB = 8;
    localparam int N_PREG = 64;
    localparam int TB = 6;

    typedef logic [TB-1:0] tag_t;
    typedef logic [N_ROB-1:0][TB-1:0] haz_vec_t;

    logic                   clock;
    logic                   reset;
    logic [N_WAY-1:0]       retire_valid;
    logic [N_WAY-1:0][TB-1:0] retire_told;
    logic                   branch_haz;
    haz_vec_t               free_list_haz;
    logic [N_WAY-1:0]       alloc_req;
    logic [N_WAY-1:0][TB-1:0] alloc_tag;
    logic [N_WAY-1:0]       alloc_valid;
    logic [TB:0]            free_count;
    logic [1:0]             avail;
    logic                   overflow_err;

    free_list dut (
        .clock         (clock),
        .reset         (reset),
        .retire_valid  (retire_valid),
        .retire_told   (retire_told),
        .branch_haz    (branch_haz),
        .free_list_haz (free_list_haz),
        .alloc_req     (alloc_req),
        .alloc_tag     (alloc_tag),
        .alloc_valid   (alloc_valid),
        .free_count    (free_count),
        .avail         (avail),
        .overflow_err  (overflow_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [1:0] valid;
        tag_t       tag0;
        tag_t       tag1;
        int         fc;
        int         av;
        logic       ovf;
    } exp_t;

    exp_t     exp_q[$];
    tag_t     model_q[$];
    logic     model_ovf;
    int       n_vec = 0;
    int       n_miss = 0;
    haz_vec_t hz0 = '0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
        end
    endtask

    task automatic model_reset();
        model_q = {};
        for (int i = 0; i < 32; i++) model_q.push_back(tag_t'(32 + i));
        model_ovf = 1'b0;
    endtask

    task automatic model_push(input tag_t t);
        if (model_q.size() < N_PREG) model_q.push_back(t);
        else model_ovf = 1'b1;
    endtask

    task automatic idle_inputs();
        alloc_req     = '0;
        retire_valid  = '0;
        retire_told   = '0;
        branch_haz    = 1'b0;
        free_list_haz = '0;
    endtask

    // Asserts reset away from any clock edge and checks the reset state before
    // the next edge, then releases it on a falling edge.
    task automatic do_reset();
        idle_inputs();
        alloc_req = 2'b11;
        reset = 1'b1;
        #2;
        check("rst_free_count", 32'(free_count), 32);
        check("rst_avail", 32'(avail), 2);
        check("rst_overflow", 32'(overflow_err), 0);
        check("rst_alloc_valid", 32'(alloc_valid), 3);
        check("rst_tag0", 32'(alloc_tag[0]), 32);
        check("rst_tag1", 32'(alloc_tag[1]), 33);
        alloc_req = '0;
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        @(posedge clock);
        #1;
    endtask

    task automatic compare();
        exp_t e;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 1, 0);
            return;
        end
        e = exp_q.pop_front();
        check("alloc_valid", 32'(alloc_valid), 32'(e.valid));
        check("alloc_tag0", 32'(alloc_tag[0]), 32'(e.tag0));
        check("alloc_tag1", 32'(alloc_tag[1]), 32'(e.tag1));
        check("free_count", 32'(free_count), 32'(e.fc));
        check("avail", 32'(avail), 32'(e.av));
        check("overflow_err", 32'(overflow_err), 32'(e.ovf));
    endtask

    // One clock cycle: drive inputs, predict outputs, advance the model.
    task automatic drive(input logic [1:0] req, input logic [1:0] rv, input tag_t t1,
                         input tag_t t0, input logic haz, input haz_vec_t hv);
        exp_t e;
        int   rank;
        int   pops;
        alloc_req      = req;
        retire_valid   = rv;
        retire_told[1] = t1;
        retire_told[0] = t0;
        branch_haz     = haz;
        free_list_haz  = hv;

        e.valid = '0;
        e.tag0  = '0;
        e.tag1  = '0;
        e.fc    = model_q.size();
        e.av    = (model_q.size() < 2) ? model_q.size() : 2;
        e.ovf   = model_ovf;
        rank = 0;
        pops = 0;
        for (int i = 0; i < N_WAY; i++) begin
            if (req[i]) begin
                if (!haz && rank < model_q.size()) begin
                    e.valid[i] = 1'b1;
                    if (i == 0) e.tag0 = model_q[rank];
                    else        e.tag1 = model_q[rank];
                    pops++;
                end
                rank++;
            end
        end
        exp_q.push_back(e);

        repeat (pops) void'(model_q.pop_front());
        if (rv[0] && t0 != 0) model_push(t0);
        if (rv[1] && t1 != 0) model_push(t1);
        if (haz) begin
            for (int j = 0; j < N_ROB; j++) begin
                if (hv[j] != 0) model_push(hv[j]);
            end
        end

        @(negedge clock);
        compare();
        @(posedge clock);
        #1;
    endtask

    initial begin
        haz_vec_t hv;
        idle_inputs();
        reset = 1'b1;
        model_reset();
        #1;
        do_reset();

        // Reset-state grants, then the following pair.
        drive(2'b11, 2'b00, 0, 0, 1'b0, hz0);
        drive(2'b11, 2'b00, 0, 0, 1'b0, hz0);
        drive(2'b00, 2'b00, 0, 0, 1'b0, hz0);

        // Lone request on way 1 takes the head tag.
        do_reset();
        drive(2'b10, 2'b00, 0, 0, 1'b0, hz0);
        drive(2'b00, 2'b00, 0, 0, 1'b0, hz0);

        // Drain to one, partial grant, then empty.
        while (model_q.size() > 2) drive(2'b11, 2'b00, 0, 0, 1'b0, hz0);
        if (model_q.size() == 2) drive(2'b01, 2'b00, 0, 0, 1'b0, hz0);
        drive(2'b11, 2'b00, 0, 0, 1'b0, hz0);
        drive(2'b11, 2'b00, 0, 0, 1'b0, hz0);

        // Retire into an empty list: the zero tag is ignored.
        drive(2'b11, 2'b11, 0, 5, 1'b0, hz0);
        drive(2'b01, 2'b00, 0, 0, 1'b0, hz0);

        // Branch flush with a simultaneous retire; no grants during the flush.
        hv = '0;
        hv[0] = 6'd40;
        hv[2] = 6'd41;
        drive(2'b11, 2'b01, 0, 7, 1'b1, hv);
        drive(2'b11, 2'b00, 0, 0, 1'b0, hz0);
        drive(2'b01, 2'b00, 0, 0, 1'b0, hz0);
        drive(2'b00, 2'b00, 0, 0, 1'b0, hz0);

        // Random traffic exercising pointer wrap and mixed events.
        for (int c = 0; c < 300; c++) begin
            hv = '0;
            for (int j = 0; j < N_ROB; j++) begin
                if ($urandom_range(0, 2) == 0) hv[j] = tag_t'($urandom_range(0, 63));
            end
            drive(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  tag_t'($urandom_range(0, 63)), tag_t'($urandom_range(0, 63)),
                  ($urandom_range(0, 15) == 0), hv);
        end

        // Fill to capacity, overflow, stickiness, then async reset mid-cycle.
        do_reset();
        for (int c = 0; model_q.size() < N_PREG; c++) begin
            drive(2'b00, 2'b11, tag_t'(1 + (2 * c) % 63), tag_t'(1 + (2 * c + 1) % 63), 1'b0, hz0);
        end
        drive(2'b00, 2'b01, 0, 9, 1'b0, hz0);
        drive(2'b00, 2'b00, 0, 0, 1'b0, hz0);
        drive(2'b11, 2'b00, 0, 0, 1'b0, hz0);
        drive(2'b00, 2'b00, 0, 0, 1'b0, hz0);
        do_reset();
        drive(2'b11, 2'b00, 0, 0, 1'b0, hz0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
